// File: rtl/valid_ready_packet_reverser_pkg.sv
// Shared types for the packet reverser: FSM state encoding and count-width helper.
package valid_ready_packet_reverser_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // Count must represent 0..depth inclusive, so one value more than the address range.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/valid_ready_packet_reverser_if.sv
// Write and read valid-ready streams of the packet reverser bundled into one interface.
interface valid_ready_packet_reverser_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] write_data;
    logic             write_last;
    logic             write_valid;
    logic             write_ready;
    logic [WIDTH-1:0] read_data;
    logic             read_last;
    logic             read_valid;
    logic             read_ready;

    modport master (
        output write_data, write_last, write_valid, read_ready,
        input  write_ready, read_data, read_last, read_valid
    );

    modport slave (
        input  write_data, write_last, write_valid, read_ready,
        output write_ready, read_data, read_last, read_valid
    );
endinterface

// File: rtl/single_port_ram.sv
// Single-port word RAM, one shared address for read and write.
// Latency: read is combinational or one cycle depending on REGISTERED_READ; no backpressure.
module single_port_ram #(
    parameter int WIDTH           = 8,
    parameter int DEPTH           = 4,
    parameter int ADDR_W          = 2,
    parameter bit REGISTERED_READ = 1'b0
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    generate
        if (REGISTERED_READ) begin : g_reg_read
            logic [WIDTH-1:0] rdata_q;
            always_ff @(posedge clk) begin
                rdata_q <= mem[addr];
            end
            assign rdata = rdata_q;
        end else begin : g_comb_read
            assign rdata = mem[addr];
        end
    endgenerate
endmodule

// File: rtl/valid_ready_packet_reverser.sv
// Buffers one last-delimited packet (up to DEPTH words) and replays it LIFO; half-duplex FILL/DRAIN.
// Latency: first reversed word the cycle after the last write; N-word packet takes 2N cycles.
// Backpressure: write_ready low while draining; output holds while read_ready low. Option: VALID_READY_PACKET_REVERSER_LENGTH_EN.
module valid_ready_packet_reverser
    import valid_ready_packet_reverser_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CNT_W = count_width(DEPTH)
) (
    input  logic                          clock,
    input  logic                          reset,
    valid_ready_packet_reverser_if.slave  bus,
    output logic                          overflow,
    output logic                          busy
`ifdef VALID_READY_PACKET_REVERSER_LENGTH_EN
    ,
    output logic [CNT_W-1:0]              read_length
`endif
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL_M1 = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              wr_fire;
    logic              rd_fire;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [WIDTH-1:0]  ram_rdata;
`ifdef VALID_READY_PACKET_REVERSER_LENGTH_EN
    logic [CNT_W-1:0]  length_q, length_d;
`endif

    assign wr_fire = (state_q == FILL)  && bus.write_valid;
    assign rd_fire = (state_q == DRAIN) && bus.read_ready;
    assign ram_we  = wr_fire;
    // One shared port: FILL writes at the top of stack, DRAIN reads the word just below it.
    assign ram_addr = (state_q == DRAIN) ? ADDR_W'(count_q - CNT_ONE) : ADDR_W'(count_q);

    single_port_ram #(
        .WIDTH           (WIDTH),
        .DEPTH           (DEPTH),
        .ADDR_W          (ADDR_W),
        .REGISTERED_READ (1'b0)
    ) u_ram (
        .clk   (clock),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (bus.write_data),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= FILL;
            count_q    <= '0;
            overflow_q <= 1'b0;
`ifdef VALID_READY_PACKET_REVERSER_LENGTH_EN
            length_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
`ifdef VALID_READY_PACKET_REVERSER_LENGTH_EN
            length_q   <= length_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        overflow_d = 1'b0;
`ifdef VALID_READY_PACKET_REVERSER_LENGTH_EN
        length_d   = length_q;
`endif
        case (state_q)
            FILL: begin
                if (wr_fire) begin
                    count_d = count_q + CNT_ONE;
                    if (bus.write_last || (count_q == CNT_FULL_M1)) begin
                        state_d = DRAIN;
`ifdef VALID_READY_PACKET_REVERSER_LENGTH_EN
                        length_d = count_q + CNT_ONE;
`endif
                    end
                    // Truncation: the rest of upstream's packet becomes the next packet.
                    if (!bus.write_last && (count_q == CNT_FULL_M1)) begin
                        overflow_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (rd_fire) begin
                    if (count_q == CNT_ONE) begin
                        state_d = FILL;
                        count_d = '0;
                    end else begin
                        count_d = count_q - CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = FILL;
                count_d = '0;
            end
        endcase
    end

    always_comb begin
        bus.write_ready = (state_q == FILL);
        bus.read_valid  = (state_q == DRAIN);
        bus.read_data   = (state_q == DRAIN) ? ram_rdata : '0;
        bus.read_last   = (state_q == DRAIN) && (count_q == CNT_ONE);
        busy            = (state_q == DRAIN);
        overflow        = overflow_q;
`ifdef VALID_READY_PACKET_REVERSER_LENGTH_EN
        read_length     = length_q;
`endif
    end
endmodule

// File: tb/tb_valid_ready_packet_reverser.sv
// Directed bench for the packet reverser; expected words queued by stimulus, checked by a monitor.
module tb_valid_ready_packet_reverser;

    typedef struct {
        logic [7:0] d;
        logic       l;
        int         len;
    } exp_t;

    logic clock;
    logic reset;
    logic overflow;
    logic busy;
`ifdef VALID_READY_PACKET_REVERSER_LENGTH_EN
    logic [2:0] read_length;
`endif

    int   n_vec  = 0;
    int   n_fail = 0;
    int   ovf_cnt = 0;
    exp_t exp_q[$];

    valid_ready_packet_reverser_if #(.WIDTH(8)) bus();

    valid_ready_packet_reverser #(.WIDTH(8), .DEPTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .overflow    (overflow),
        .busy        (busy)
`ifdef VALID_READY_PACKET_REVERSER_LENGTH_EN
        ,
        .read_length (read_length)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic l, input int len);
        exp_t e;
        e.d = d; e.l = l; e.len = len;
        exp_q.push_back(e);
    endtask

    // Entered and left just after a rising edge.
    task automatic write_word(input logic [7:0] d, input logic l);
        int n = 0;
        bus.write_data  = d;
        bus.write_last  = l;
        bus.write_valid = 1'b1;
        @(negedge clock);
        while (!bus.write_ready && n < 100) begin
            n++;
            @(negedge clock);
        end
        if (n >= 100) chk("write_timeout", 1, 0);
        @(posedge clock); #1;
        bus.write_valid = 1'b0;
    endtask

    // Returns at the negedge where the read_last handshake is presented.
    task automatic wait_last();
        int n = 0;
        @(negedge clock);
        while (!(bus.read_valid && bus.read_ready && bus.read_last) && n < 100) begin
            n++;
            @(negedge clock);
        end
        if (n >= 100) chk("drain_timeout", 1, 0);
    endtask

    // Monitor: compares every read handshake against the scoreboard.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (overflow) ovf_cnt++;
                if (bus.read_valid && bus.read_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", {23'd0, bus.read_last, bus.read_data}, 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("read_data", {24'd0, bus.read_data}, {24'd0, e.d});
                        chk("read_last", {31'd0, bus.read_last}, {31'd0, e.l});
`ifdef VALID_READY_PACKET_REVERSER_LENGTH_EN
                        chk("read_length", {29'd0, read_length}, e.len);
`endif
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        clock           = 1'b0;
        reset           = 1'b1;
        bus.write_data  = '0;
        bus.write_last  = 1'b0;
        bus.write_valid = 1'b0;
        bus.read_ready  = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clock);
        chk("rst_write_ready", {31'd0, bus.write_ready}, 1);
        chk("rst_read_valid",  {31'd0, bus.read_valid}, 0);
        chk("rst_read_last",   {31'd0, bus.read_last}, 0);
        chk("rst_read_data",   {24'd0, bus.read_data}, 0);
        chk("rst_overflow",    {31'd0, overflow}, 0);
        chk("rst_busy",        {31'd0, busy}, 0);
`ifdef VALID_READY_PACKET_REVERSER_LENGTH_EN
        chk("rst_read_length", {29'd0, read_length}, 0);
`endif
        @(posedge clock); #1;

        // Three-word packet
        push(8'h33, 1'b0, 3); push(8'h22, 1'b0, 3); push(8'h11, 1'b1, 3);
        write_word(8'h11, 1'b0);
        write_word(8'h22, 1'b0);
        write_word(8'h33, 1'b1);
        wait_last();
        @(negedge clock);
        chk("t1_write_ready_after_last", {31'd0, bus.write_ready}, 1);
        chk("t1_busy_after_last", {31'd0, busy}, 0);
        chk("t1_no_overflow", ovf_cnt, 0);
        @(posedge clock); #1;

        // Single-word packet: busy for exactly one cycle
        push(8'hA5, 1'b1, 1);
        write_word(8'hA5, 1'b1);
        n = 0;
        @(negedge clock);
        while (busy && n < 20) begin
            n++;
            @(negedge clock);
        end
        chk("t2_busy_cycles", n, 1);
        @(posedge clock); #1;

        // Truncation at DEPTH: 01..04 then 06,05
        push(8'h04, 1'b0, 4); push(8'h03, 1'b0, 4); push(8'h02, 1'b0, 4); push(8'h01, 1'b1, 4);
        push(8'h06, 1'b0, 2); push(8'h05, 1'b1, 2);
        write_word(8'h01, 1'b0);
        write_word(8'h02, 1'b0);
        write_word(8'h03, 1'b0);
        write_word(8'h04, 1'b0);
        @(negedge clock);
        chk("t3_overflow_pulse", {31'd0, overflow}, 1);
        chk("t3_write_ready_full", {31'd0, bus.write_ready}, 0);
        @(negedge clock);
        chk("t3_overflow_one_cycle", {31'd0, overflow}, 0);
        @(posedge clock); #1;
        write_word(8'h05, 1'b0);
        write_word(8'h06, 1'b1);
        wait_last();
        chk("t3_overflow_count", ovf_cnt, 1);
        @(posedge clock); #1;

        // Backpressure mid-drain with ignored write_valid
        bus.read_ready = 1'b0;
        push(8'h60, 1'b0, 3); push(8'h50, 1'b0, 3); push(8'h40, 1'b1, 3);
        write_word(8'h40, 1'b0);
        write_word(8'h50, 1'b0);
        write_word(8'h60, 1'b1);
        bus.read_ready = 1'b1;
        @(posedge clock); #1;
        bus.read_ready  = 1'b0;
        bus.write_data  = 8'hEE;
        bus.write_last  = 1'b1;
        bus.write_valid = 1'b1;
        repeat (5) begin
            @(negedge clock);
            chk("t4_stall_data",  {24'd0, bus.read_data}, 32'h50);
            chk("t4_stall_last",  {31'd0, bus.read_last}, 0);
            chk("t4_stall_valid", {31'd0, bus.read_valid}, 1);
            chk("t4_stall_wrdy",  {31'd0, bus.write_ready}, 0);
        end
        @(posedge clock); #1;
        bus.write_valid = 1'b0;
        bus.read_ready  = 1'b1;
        wait_last();
        @(posedge clock); #1;

        // Reset during drain after one word read
        bus.read_ready = 1'b0;
        push(8'h83, 1'b0, 3);
        write_word(8'h81, 1'b0);
        write_word(8'h82, 1'b0);
        write_word(8'h83, 1'b1);
        bus.read_ready = 1'b1;
        @(posedge clock); #1;
        bus.read_ready = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("t5_read_valid", {31'd0, bus.read_valid}, 0);
        chk("t5_write_ready", {31'd0, bus.write_ready}, 1);
        chk("t5_busy", {31'd0, busy}, 0);
`ifdef VALID_READY_PACKET_REVERSER_LENGTH_EN
        chk("t5_read_length", {29'd0, read_length}, 0);
`endif
        @(posedge clock); #1;
        bus.read_ready = 1'b1;
        push(8'h7E, 1'b1, 1);
        write_word(8'h7E, 1'b1);
        wait_last();
        @(posedge clock); #1;

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            n++;
            @(posedge clock);
        end
        repeat (5) @(posedge clock);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
